// File: rtl/bip_pkg.sv
// Shared definitions for the BIP controller: opcodes, FSM states, datapath select encodings.
package bip_pkg;

  localparam int unsigned OPC_W = 5;

  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_HLT  = 5'd0;
  localparam opcode_t OP_STO  = 5'd1;
  localparam opcode_t OP_LD   = 5'd2;
  localparam opcode_t OP_LDI  = 5'd3;
  localparam opcode_t OP_ADD  = 5'd4;
  localparam opcode_t OP_ADDI = 5'd5;
  localparam opcode_t OP_SUB  = 5'd6;
  localparam opcode_t OP_SUBI = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  localparam logic [1:0] SEL_A_MEM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic       SEL_B_MEM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

  typedef struct packed {
    logic       wr_ram;
    logic       rd_ram;
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Opcode to datapath control decoder; unknown opcodes decode to all-zero (NOP).
module bip_decoder
  import bip_pkg::*;
(
  input  opcode_t opcode,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_STO:  ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_MEM;
      end
      OP_LDI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_IMM;
      end
      OP_ADD, OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_MEM;
        ctrl.op     = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.wr_acc = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.op     = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: 3-cycle FETCH/DECODE/EXEC sequencer holding PC and IR.
module bip_control
  import bip_pkg::*;
#(
  parameter int unsigned NB_INSTRUC = 16,
  parameter int unsigned NB_OPCODE  = 5,
  parameter int unsigned NB_OPERAND = 11,
  parameter int unsigned NB_ADDR    = 11
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [NB_INSTRUC-1:0] i_instruc,
  output logic [NB_ADDR-1:0]    o_addr_program_mem,
  output logic [NB_ADDR-1:0]    o_addr_data_mem,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic                  o_WrRam,
  output logic                  o_RdRam,
  output logic                  o_WrAcc,
  output logic [1:0]            o_SelA,
  output logic                  o_SelB,
  output logic                  o_Op,
  output logic                  o_busy,
  output logic                  o_halt
);

  state_t                  state;
  logic [NB_ADDR-1:0]      pc;
  logic [NB_INSTRUC-1:0]   ir;
  opcode_t                 ir_opcode;
  opcode_t                 in_opcode;
  opcode_t                 dec_opcode;
  ctrl_t                   ctrl;
  logic                    in_decode;
  logic                    in_exec;

  assign ir_opcode = opcode_t'(ir[NB_INSTRUC-1 -: NB_OPCODE]);
  assign in_opcode = opcode_t'(i_instruc[NB_INSTRUC-1 -: NB_OPCODE]);

  // Sequencer, PC, IR and status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      o_busy <= 1'b0;
      o_halt <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (i_start) begin
            state  <= ST_FETCH;
            o_busy <= 1'b1;
          end
        end
        ST_FETCH:  state <= ST_DECODE;
        ST_DECODE: begin
          state <= ST_EXEC;
          ir    <= i_instruc;
        end
        ST_EXEC: begin
          if (ir_opcode == OP_HLT) begin
            state  <= ST_HALT;
            o_busy <= 1'b0;
            o_halt <= 1'b1;
          end else begin
            state <= ST_FETCH;
            pc    <= pc + NB_ADDR'(1);
          end
        end
        ST_HALT: state <= ST_HALT;
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_halt <= 1'b0;
        end
      endcase
    end
  end

  // One shared decoder: looks at the incoming word in DECODE (early RdRam), at IR otherwise.
  assign in_decode  = (state == ST_DECODE);
  assign in_exec    = (state == ST_EXEC);
  assign dec_opcode = in_decode ? in_opcode : ir_opcode;

  bip_decoder u_decoder (
    .opcode (dec_opcode),
    .ctrl   (ctrl)
  );

  assign o_addr_program_mem = pc;
  assign o_addr_data_mem    = in_decode ? NB_ADDR'(i_instruc[NB_OPERAND-1:0])
                                        : NB_ADDR'(ir[NB_OPERAND-1:0]);
  assign o_operand          = ir[NB_OPERAND-1:0];
  assign o_RdRam            = in_decode & ctrl.rd_ram;
  assign o_WrRam            = in_exec & ctrl.wr_ram;
  assign o_WrAcc            = in_exec & ctrl.wr_acc;
  assign o_SelA             = in_exec ? ctrl.sel_a : SEL_A_MEM;
  assign o_SelB             = in_exec ? ctrl.sel_b : SEL_B_MEM;
  assign o_Op               = in_exec ? ctrl.op    : ALU_ADD;

endmodule

// File: tb/tb_bip_control.sv
// Self-checking bench for bip_control: opcode table, directed programs, random programs, wrap and reset.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] instr;
  logic [10:0] addr_pm, addr_dm, operand;
  logic        wr_ram, rd_ram, wr_acc, sel_b, op, busy, halt;
  logic [1:0]  sel_a;

  int checks = 0;
  int errors = 0;

  logic [15:0] prog [0:2047];

  typedef struct packed {
    logic [10:0] pc;
    logic [10:0] daddr;
    logic [10:0] operand;
    logic        wr_ram;
    logic        rd_ram;
    logic        wr_acc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        busy;
    logic        halt;
  } obs_t;

  // Instruction-set table: what each defined opcode does in its execute cycle.
  typedef struct packed {
    logic [4:0] opc;
    logic       wr_ram;
    logic       wr_acc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       rd_mem;
  } isa_t;

  isa_t tbl [0:7];

  always #5 clk = ~clk;

  bip_control dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_instruc          (instr),
    .o_addr_program_mem (addr_pm),
    .o_addr_data_mem    (addr_dm),
    .o_operand          (operand),
    .o_WrRam            (wr_ram),
    .o_RdRam            (rd_ram),
    .o_WrAcc            (wr_acc),
    .o_SelA             (sel_a),
    .o_SelB             (sel_b),
    .o_Op               (op),
    .o_busy             (busy),
    .o_halt             (halt)
  );

  // Synchronous program ROM: data valid one cycle after the address.
  always @(posedge clk) instr <= prog[addr_pm];

  function automatic obs_t model(int p, logic [4:0] opc, logic [10:0] opr, int k, logic [10:0] iro);
    obs_t e = '0;
    e.pc      = 11'(k % 2048);
    e.busy    = 1'b1;
    e.daddr   = iro;
    e.operand = iro;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].opc == opc) begin
        if (p == 1) e.rd_ram = tbl[i].rd_mem;
        if (p == 2) begin
          e.wr_ram = tbl[i].wr_ram;
          e.wr_acc = tbl[i].wr_acc;
          e.sel_a  = tbl[i].sel_a;
          e.sel_b  = tbl[i].sel_b;
          e.op     = tbl[i].op;
        end
      end
    end
    if (p == 1) e.daddr = opr;
    if (p == 2) begin
      e.daddr   = opr;
      e.operand = opr;
    end
    return e;
  endfunction

  task automatic cmp(string nm, obs_t e);
    obs_t a;
    a = '{addr_pm, addr_dm, operand, wr_ram, rd_ram, wr_acc, sel_a, sel_b, op, busy, halt};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got pc=%h da=%h opr=%h wr=%b rd=%b wa=%b sa=%0d sb=%b op=%b busy=%b halt=%b, expected pc=%h da=%h opr=%h wr=%b rd=%b wa=%b sa=%0d sb=%b op=%b busy=%b halt=%b",
               nm, $time, a.pc, a.daddr, a.operand, a.wr_ram, a.rd_ram, a.wr_acc, a.sel_a, a.sel_b, a.op, a.busy, a.halt,
               e.pc, e.daddr, e.operand, e.wr_ram, e.rd_ram, e.wr_acc, e.sel_a, e.sel_b, e.op, e.busy, e.halt);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reset, start, then follow the program instruction by instruction until HLT or max_instr.
  task automatic run_prog(string nm, int max_instr, bit rnd_start);
    logic [10:0] iro = '0;
    logic [4:0]  opc;
    logic [10:0] opr;
    bit          halted = 1'b0;
    int          hlt_k = 0;
    obs_t        e;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < max_instr && !halted; k++) begin
      opc = prog[k % 2048][15:11];
      opr = prog[k % 2048][10:0];
      for (int p = 0; p < 3; p++) begin
        cmp(nm, model(p, opc, opr, k, iro));
        start = rnd_start ? 1'($urandom) : 1'b0;
        @(negedge clk);
      end
      iro = opr;
      if (opc == 5'd0) begin
        halted = 1'b1;
        hlt_k  = k;
      end
    end
    start = 1'b0;
    if (halted) begin
      for (int c = 0; c < 4; c++) begin
        e = '0;
        e.pc      = 11'(hlt_k % 2048);
        e.halt    = 1'b1;
        e.daddr   = iro;
        e.operand = iro;
        cmp({nm, "_halt"}, e);
        start = 1'b1;
        @(negedge clk);
      end
      start = 1'b0;
    end
  endtask

  initial begin
    obs_t z = '0;
    int   n;
    //            opc    wrR   wrA   selA   selB  op    rdM
    tbl[0] = '{5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{5'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd2, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{5'd3, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{5'd4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{5'd5, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{5'd6, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{5'd7, 1'b0, 1'b1, 2'd2, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 2048; i++) prog[i] = 16'h0000;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);

    // Idle after reset, then reset wins over a simultaneous start.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      cmp("idle", z);
      @(negedge clk);
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    cmp("rst_vs_start", z);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    cmp("rst_vs_start_idle", z);

    // Every opcode in the table plus some NOP codes, each followed by HLT.
    for (int i = 0; i < 11; i++) begin
      logic [4:0] oc;
      oc = (i < 8) ? tbl[i].opc : ((i == 8) ? 5'd8 : ((i == 9) ? 5'd20 : 5'd31));
      prog[0] = {oc, 11'($urandom)};
      prog[1] = 16'h0000;
      run_prog($sformatf("op%0d", oc), 4, 1'b0);
    end

    // LD 5 / STO 6; immediates; ADD 3 / HLT.
    prog[0] = {5'd2, 11'h005}; prog[1] = {5'd1, 11'h006}; prog[2] = 16'h0000;
    run_prog("ld_sto", 4, 1'b0);
    prog[0] = {5'd3, 11'h7FF}; prog[1] = {5'd5, 11'h001}; prog[2] = {5'd7, 11'h002}; prog[3] = 16'h0000;
    run_prog("imm", 5, 1'b0);
    prog[0] = {5'd4, 11'h003}; prog[1] = 16'h0000;
    run_prog("add_hlt", 4, 1'b1);

    // Random programs terminated by HLT, with i_start toggling while busy.
    for (int r = 0; r < 20; r++) begin
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog[i] = 16'($urandom);
      prog[n] = {5'd0, 11'($urandom)};
      run_prog("rand", n + 1, 1'b1);
    end

    // PC wrap over a memory full of NOPs.
    for (int i = 0; i < 2048; i++) prog[i] = {5'd31, 11'($urandom)};
    run_prog("wrap", 2050, 1'b0);

    // Reset while a STO is in EXEC.
    prog[0] = {5'd1, 11'h006};
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    cmp("sto_exec", model(2, 5'd1, 11'h006, 0, 11'h000));
    rst = 1'b1;
    @(negedge clk);
    cmp("rst_in_exec", z);
    rst = 1'b0;
    @(negedge clk);
    cmp("rst_in_exec_idle", z);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
